cpu_trace_monitor: RTL
======================

# cpu_trace_monitor

Synthesizable, parametrised commit-trace recorder that sits beside the `cpu` top level. Each cycle it samples the core's retirement signals: register write, memory read/write, address, data, PC and halt. It classifies each retirement as NOP/ALU/LD/ST/HALT, numbers it, and pushes a trace record into a FIFO drained over a valid/ready port. It also keeps cycle and instruction counters, detects a runaway cycle limit, and signals completion once the trace after halt has fully drained.

## Interface
- `DATA_W`, 16, width of PC, data and address fields
- `REG_W`, 4, register-index width
- `CNT_W`, 32, width of cycle/instruction counters and record number
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `CYCLE_LIMIT`, 100000, cycle count that triggers timeout
- `COUNT_NOPS`, 1, 1: non-writing, non-halt commits are recorded/counted as NOP; 0: they are dropped
- `clk` in 1 — single clock; all logic on posedge
- `rst` in 1 — reset is synchronous and active-high
- `commit_valid` in 1 — a retirement is presented this cycle
- `pc` in DATA_W — PC of retiring instruction
- `reg_write` in 1; `write_reg` in REG_W; `write_data` in DATA_W
- `mem_read` in 1; `mem_write` in 1; `mem_addr` in DATA_W; `mem_data` in DATA_W
- `halt` in 1 — halt retiring
- `rec_valid` out 1; `rec_ready` in 1 — FIFO head handshake
- `rec_kind` out 3 — 0 NOP, 1 ALU, 2 LD, 3 ST, 4 HALT
- `rec_inum` out CNT_W; `rec_pc` out DATA_W; `rec_reg` out REG_W; `rec_value` out DATA_W; `rec_addr` out DATA_W
- `inst_count` out CNT_W; `cycle_count` out CNT_W
- `overflow` out 1 — sticky: at least one record was dropped
- `timeout` out 1 — sticky: CYCLE_LIMIT reached
- `done` out 1 — halted or timed out, and FIFO empty

## Operation
- States: RUN, DRAIN, DONE. Reset puts the block in RUN with FIFO empty and all outputs 0.
- RUN:
  - `cycle_count` +1 every cycle.
  - On `commit_valid`, classify with priority:
    - `reg_write & mem_read` → LD (reg=`write_reg`, value=`write_data`, addr=`mem_addr`)
    - `reg_write` → ALU (reg, value=`write_data`, addr=0)
    - `halt` → HALT (reg/value/addr=0)
    - `mem_write` → ST (reg=0, value=`mem_data`, addr=`mem_addr`)
    - else → NOP (all zero)
  - Record is accepted if it is not NOP, or if `COUNT_NOPS`=1. An accepted record gets `rec_inum`=current `inst_count`, then `inst_count` +1.
- Push while FIFO full and no pop in the same cycle: record dropped, `overflow` set, `inst_count` still increments.
- HALT record accepted → DRAIN. Commits are ignored from the next cycle on. `cycle_count` freezes.
- `cycle_count` reaching CYCLE_LIMIT in RUN → `timeout` set, go to DRAIN; a commit in that same cycle is still recorded.
- DRAIN → DONE when FIFO is empty. DONE holds until `rst`; `done`=1 in DONE only.
- FIFO: circular buffer, pointers of width log2(DEPTH)+1, wrap modulo DEPTH. Simultaneous push and pop when full is legal (no drop). Simultaneous push and pop when empty: the record passes through the FIFO and appears the next cycle.
- Counters wrap modulo 2^CNT_W with no flag.
- `rst` in any state, including mid-drain: FIFO flushed, counters and stickies cleared, RUN.

## Timing
- Capture on the posedge where `commit_valid`=1. The record is at the FIFO head, with `rec_valid`=1, the following cycle (1-cycle latency when empty).
- `rec_*` are stable while `rec_valid & !rec_ready`. A pop occurs on the posedge with `rec_valid & rec_ready`.
- `inst_count`, `cycle_count`, `overflow` and `timeout` are registered and reflect the previous edge.
- `done` rises the cycle after the final pop in DRAIN.
- All outputs are 0 in the cycle after `rst` is sampled high.

## Test plan
- Reset: hold `rst` 2 cycles → `rec_valid`=0, `inst_count`=0, `cycle_count`=0, `done`=0, `overflow`=0.
- Mixed stream, `rec_ready`=1, then check records in order:
  - ALU (pc 0x0000, reg 3, data 0x1234) → kind 1, inum 0, value 0x1234
  - LD (pc 0x0002, reg 5, data 0xBEEF, addr 0x0040) → kind 2, inum 1, addr 0x0040
  - ST (pc 0x0004, addr 0x0042, data 0x00AA) → kind 3, inum 2, reg 0
  - NOP (pc 0x0006) → kind 0, inum 3
- `COUNT_NOPS`=0: ALU, NOP, ALU → two records with inum 0 and 1; `inst_count`=2.
- `DEPTH`=4, `rec_ready`=0, six ALU commits → `overflow`=1, `inst_count`=6. Then raise `rec_ready` → exactly four records, inum 0–3.
- HALT at pc 0x0010 with 2 earlier records queued, `rec_ready` toggling → 3 records, last kind 4; later commits ignored; `done`=1 the cycle after the last pop.
- `CYCLE_LIMIT`=20, no halt → `timeout`=1 at `cycle_count`=20 and `done`=1 once empty. Assert `rst` mid-drain with records queued → FIFO empty, all outputs 0, RUN.

Source files
------------

// File: rtl/cpu_trace_monitor.sv
// cpu_trace_monitor
//
// Commit-trace recorder that sits beside the cpu top level. Every retirement
// presented on commit_valid is classified (NOP/ALU/LD/ST/HALT), numbered with
// the running instruction count and queued in a small circular FIFO. The
// block also keeps cycle/instruction counters, flags a runaway cycle limit
// and reports completion once the trace after halt (or timeout) has drained.
//
// Ports
//   clk, rst          : single clock, synchronous active-high reset
//   commit_valid, pc  : retirement strobe and its PC
//   reg_write, write_reg, write_data       : register write of the retirement
//   mem_read, mem_write, mem_addr, mem_data : memory access of the retirement
//   halt              : halt retiring
//   rec_valid/rec_ready and rec_kind, rec_inum, rec_pc, rec_reg, rec_value,
//   rec_addr          : FIFO head record
//   inst_count, cycle_count : registered counters
//   overflow, timeout : sticky flags
//   done              : halted or timed out, and the FIFO has drained
//   dbg_state         : current FSM state (0 RUN, 1 DRAIN, 2 DONE)
//
// Record handshake: rec_valid is high whenever the FIFO holds a record and
// the rec_* fields then show the head record, held stable until it is taken.
// A record is taken on the posedge where rec_valid and rec_ready are both
// high; rec_ready may be driven freely and has no effect while rec_valid=0.
// When rec_valid is low all rec_* fields read zero.

module cpu_trace_monitor #(
  parameter int          DATA_W      = 16,
  parameter int          REG_W       = 4,
  parameter int          CNT_W       = 32,
  parameter int          DEPTH       = 8,
  parameter int unsigned CYCLE_LIMIT = 100000,
  parameter bit          COUNT_NOPS  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              commit_valid,
  input  logic [DATA_W-1:0] pc,
  input  logic              reg_write,
  input  logic [REG_W-1:0]  write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              halt,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [2:0]        rec_kind,
  output logic [CNT_W-1:0]  rec_inum,
  output logic [DATA_W-1:0] rec_pc,
  output logic [REG_W-1:0]  rec_reg,
  output logic [DATA_W-1:0] rec_value,
  output logic [DATA_W-1:0] rec_addr,
  output logic [CNT_W-1:0]  inst_count,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              overflow,
  output logic              timeout,
  output logic              done,
  output logic [1:0]        dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int REC_W = 3 + CNT_W + DATA_W + REG_W + DATA_W + DATA_W;

  localparam logic [2:0] KIND_NOP  = 3'd0;
  localparam logic [2:0] KIND_ALU  = 3'd1;
  localparam logic [2:0] KIND_LD   = 3'd2;
  localparam logic [2:0] KIND_ST   = 3'd3;
  localparam logic [2:0] KIND_HALT = 3'd4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [REC_W-1:0]  mem_q [DEPTH];
  logic [PTR_W:0]    wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic [CNT_W-1:0]  inst_count_q, cycle_count_q;
  logic              overflow_q, timeout_q;

  logic [2:0]        kind_c;
  logic [REG_W-1:0]  reg_c;
  logic [DATA_W-1:0] value_c, addr_c;
  logic [REC_W-1:0]  rec_c, head;
  logic              accept, fifo_empty, fifo_full, pop, push_ok, drop;
  logic              hit_limit, empty_next;
  logic [CNT_W-1:0]  cycle_inc;

  // Classification, highest priority first: a register write that also
  // reads memory is a load, a plain register write is ALU work.
  always_comb begin
    kind_c  = KIND_NOP;
    reg_c   = '0;
    value_c = '0;
    addr_c  = '0;
    if (reg_write && mem_read) begin
      kind_c  = KIND_LD;
      reg_c   = write_reg;
      value_c = write_data;
      addr_c  = mem_addr;
    end else if (reg_write) begin
      kind_c  = KIND_ALU;
      reg_c   = write_reg;
      value_c = write_data;
    end else if (halt) begin
      kind_c  = KIND_HALT;
    end else if (mem_write) begin
      kind_c  = KIND_ST;
      value_c = mem_data;
      addr_c  = mem_addr;
    end
  end

  assign rec_c = {kind_c, inst_count_q, pc, reg_c, value_c, addr_c};

  assign accept     = (state_q == ST_RUN) && commit_valid &&
                      (COUNT_NOPS || (kind_c != KIND_NOP));
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop        = !fifo_empty && rec_ready;
  // A pop in the same cycle frees the slot, so a full FIFO only drops
  // when nothing is leaving.
  assign push_ok    = accept && (!fifo_full || pop);
  assign drop       = accept && fifo_full && !pop;

  assign wr_ptr_d   = wr_ptr_q + {{PTR_W{1'b0}}, push_ok};
  assign rd_ptr_d   = rd_ptr_q + {{PTR_W{1'b0}}, pop};
  assign empty_next = (wr_ptr_d == rd_ptr_d);

  assign cycle_inc  = cycle_count_q + 1'b1;
  assign hit_limit  = (state_q == ST_RUN) && (cycle_inc == CNT_W'(CYCLE_LIMIT));

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if ((accept && (kind_c == KIND_HALT)) || hit_limit) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Look at the post-pop occupancy so done follows the final pop by
        // exactly one cycle.
        if (empty_next) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      inst_count_q  <= '0;
      cycle_count_q <= '0;
      overflow_q    <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (accept) inst_count_q <= inst_count_q + 1'b1;
      if (state_q == ST_RUN) cycle_count_q <= cycle_inc;
      if (drop) overflow_q <= 1'b1;
      if (hit_limit) timeout_q <= 1'b1;
    end
  end

  // Storage carries no reset; an empty FIFO masks whatever it holds.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_ptr_q[PTR_W-1:0]] <= rec_c;
  end

  assign head = fifo_empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];

  assign rec_valid   = !fifo_empty;
  assign {rec_kind, rec_inum, rec_pc, rec_reg, rec_value, rec_addr} = head;
  assign inst_count  = inst_count_q;
  assign cycle_count = cycle_count_q;
  assign overflow    = overflow_q;
  assign timeout     = timeout_q;
  assign done        = (state_q == ST_DONE);
  assign dbg_state   = state_q;

endmodule
